fu_result_buffer: RTL and testbench

//  Per-FU result holding buffer sitting between the functional units and complete_stage.
//  - Captures one finished result per FU.
//  - Each cycle, selects up to CDB_W held results, oldest first, and presents them as complete packets.
//  - Retains unselected or stalled results and back-pressures each FU through fu_ready.
//  - Producer end of the FU->complete interface: it generates the finish/packet traffic that complete_stage consumes.

---
 rtl/fu_result_buffer.sv | 98 +++++++++
 tb/tb_fu_result_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_result_buffer.sv
// fu_result_buffer: per-FU result holding slots feeding complete lanes oldest-first.
// Define FU_BUF_PERF_EN to add the saturating stall_cycles counter port.
module fu_result_buffer #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int PR_W   = 6,
  parameter int XLEN   = 32,
  parameter int AGE_W  = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_FU-1:0]      fu_done,
  input  logic [NUM_FU*PR_W-1:0] fu_pr,
  input  logic [NUM_FU*XLEN-1:0] fu_value,
  input  logic [NUM_FU-1:0]      fu_br,
  output logic [NUM_FU-1:0]      fu_ready,
  input  logic                   cdb_stall,
  output logic [CDB_W-1:0]       c_valid,
  output logic [CDB_W*PR_W-1:0]  c_pr,
  output logic [CDB_W*XLEN-1:0]  c_value,
  output logic [CDB_W-1:0]       c_br,
  output logic [CDB_W*3-1:0]     c_src
`ifdef FU_BUF_PERF_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);
  localparam int RK_W = $clog2(NUM_FU) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  logic [NUM_FU-1:0] valid;
  logic [NUM_FU-1:0] br;
  logic [NUM_FU-1:0] sel;
  logic [PR_W-1:0]   pr    [NUM_FU];
  logic [XLEN-1:0]   value [NUM_FU];
  logic [AGE_W-1:0]  age   [NUM_FU];
  // A slot's lane is the number of valid slots that outrank it (older, or equal age and lower index).
  always_comb begin
    logic [RK_W-1:0] r;
    sel = '0;
    c_valid = '0;
    c_pr = '0;
    c_value = '0;
    c_br = '0;
    c_src = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      r = '0;
      for (int j = 0; j < NUM_FU; j++)
        if (j != i && valid[j] && (age[j] > age[i] || (age[j] == age[i] && j < i)))
          r = r + 1'b1;
      for (int k = 0; k < CDB_W; k++)
        if (valid[i] && r == RK_W'(k)) begin
          sel[i] = 1'b1;
          c_valid[k] = 1'b1;
          c_pr[k*PR_W +: PR_W] = pr[i];
          c_value[k*XLEN +: XLEN] = value[i];
          c_br[k] = br[i];
          c_src[k*3 +: 3] = 3'(i);
        end
    end
  end
  assign fu_ready = ~valid | (sel & {NUM_FU{~cdb_stall}});
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      br <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        pr[i] <= '0;
        value[i] <= '0;
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_done[i] && fu_ready[i]) begin
          valid[i] <= 1'b1;
          pr[i] <= fu_pr[i*PR_W +: PR_W];
          value[i] <= fu_value[i*XLEN +: XLEN];
          br[i] <= fu_br[i];
          age[i] <= '0;
        end else if (sel[i] && !cdb_stall) begin
          valid[i] <= 1'b0;
          age[i] <= '0;
        end else if (valid[i] && age[i] != AGE_MAX) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end
`ifdef FU_BUF_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset)
      stall_cycles <= '0;
    else if (cdb_stall && |valid && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif
  // A producer offering into a slot that cannot accept loses that result.
  assert property (@(posedge clock) disable iff (!reset) (fu_done & ~fu_ready) == '0);
endmodule

// File: tb/tb_fu_result_buffer.sv
// tb_fu_result_buffer: directed vector table plus hand sequences for fu_result_buffer.
module tb_fu_result_buffer;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   fu_done = '0;
  logic [47:0]  fu_pr;
  logic [255:0] fu_value;
  logic [7:0]   fu_br;
  logic [7:0]   fu_ready;
  logic         cdb_stall = 1'b0;
  logic [2:0]   c_valid;
  logic [17:0]  c_pr;
  logic [95:0]  c_value;
  logic [2:0]   c_br;
  logic [8:0]   c_src;
`ifdef FU_BUF_PERF_EN
  logic [15:0]  stall_cycles;
`endif
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  fu_result_buffer dut (
    .clock(clock), .reset(reset), .fu_done(fu_done), .fu_pr(fu_pr), .fu_value(fu_value),
    .fu_br(fu_br), .fu_ready(fu_ready), .cdb_stall(cdb_stall), .c_valid(c_valid),
    .c_pr(c_pr), .c_value(c_value), .c_br(c_br), .c_src(c_src)
`ifdef FU_BUF_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  typedef struct {
    logic [7:0] done;
    logic       stall;
    logic [2:0] ev;
    logic [8:0] es;
    logic [7:0] er;
  } vec_t;
  vec_t tv [12];
  function automatic logic [5:0] pr_of(int i);
    return 6'(16 + i);
  endfunction
  function automatic logic [31:0] val_of(int i);
    return 32'hA5A5_0000 + 32'(i * 32'h111);
  endfunction
  task automatic set_defaults();
    for (int i = 0; i < 8; i++) begin
      fu_pr[i*6 +: 6] = pr_of(i);
      fu_value[i*32 +: 32] = val_of(i);
      fu_br[i] = i[0];
    end
  endtask
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_lanes(string nm, logic [2:0] ev, logic [8:0] es);
    logic [17:0] ep;
    logic [95:0] evl;
    logic [2:0]  eb;
    int s;
    ep = '0;
    evl = '0;
    eb = '0;
    for (int k = 0; k < 3; k++)
      if (ev[k]) begin
        s = int'(es[k*3 +: 3]);
        ep[k*6 +: 6] = pr_of(s);
        evl[k*32 +: 32] = val_of(s);
        eb[k] = s[0];
      end
    chk({nm, ".valid"}, 64'(c_valid), 64'(ev));
    chk({nm, ".src"}, 64'(c_src), 64'(es));
    chk({nm, ".pr"}, 64'(c_pr), 64'(ep));
    chk({nm, ".value"}, c_value[63:0], evl[63:0]);
    chk({nm, ".value2"}, 64'(c_value[95:64]), 64'(evl[95:64]));
    chk({nm, ".br"}, 64'(c_br), 64'(eb));
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  initial begin
    tv[0]  = '{8'h00, 1'b0, 3'b000, 9'o000, 8'hFF};
    tv[1]  = '{8'hFF, 1'b0, 3'b000, 9'o000, 8'hFF};
    tv[2]  = '{8'h00, 1'b0, 3'b111, 9'o210, 8'h07};
    tv[3]  = '{8'h00, 1'b0, 3'b111, 9'o543, 8'h3F};
    tv[4]  = '{8'h00, 1'b0, 3'b011, 9'o076, 8'hFF};
    tv[5]  = '{8'h00, 1'b0, 3'b000, 9'o000, 8'hFF};
    tv[6]  = '{8'h20, 1'b0, 3'b000, 9'o000, 8'hFF};
    tv[7]  = '{8'h00, 1'b1, 3'b001, 9'o005, 8'hDF};
    tv[8]  = '{8'h02, 1'b1, 3'b001, 9'o005, 8'hDF};
    tv[9]  = '{8'h00, 1'b1, 3'b011, 9'o015, 8'hDD};
    tv[10] = '{8'h00, 1'b0, 3'b011, 9'o015, 8'hFF};
    tv[11] = '{8'h00, 1'b0, 3'b000, 9'o000, 8'hFF};
    set_defaults();
    repeat (2) cyc();
    reset = 1'b1;
    #1;
    chk_lanes("reset", 3'b000, 9'o000);
    chk("reset.ready", 64'(fu_ready), 64'hFF);
`ifdef FU_BUF_PERF_EN
    chk("reset.stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      fu_done = tv[i].done;
      cdb_stall = tv[i].stall;
      #1;
      chk_lanes($sformatf("vec%0d", i), tv[i].ev, tv[i].es);
      chk($sformatf("vec%0d.ready", i), 64'(fu_ready), 64'(tv[i].er));
      cyc();
    end
    // Drain and refill slot 2 in one cycle.
    fu_done = 8'h04;
    cdb_stall = 1'b0;
    cyc();
    fu_pr[12 +: 6] = 6'b101001;
    fu_value[64 +: 32] = 32'h8251dabe;
    fu_br[2] = 1'b1;
    #1;
    chk_lanes("refill_old", 3'b001, 9'o002);
    chk("refill_old.ready", 64'(fu_ready), 64'hFF);
    cyc();
    fu_done = 8'h00;
    #1;
    chk("refill_new.valid", 64'(c_valid), 64'b001);
    chk("refill_new.src", 64'(c_src), 64'o002);
    chk("refill_new.pr", 64'(c_pr), 64'b101001);
    chk("refill_new.value", 64'(c_value), 64'h8251dabe);
    chk("refill_new.br", 64'(c_br), 64'b001);
    cyc();
    set_defaults();
    #1;
    chk_lanes("refill_done", 3'b000, 9'o000);
    // All slots full under a 10-cycle stall.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    fu_done = 8'hFF;
    cdb_stall = 1'b1;
    #1;
    chk("full_fill.ready", 64'(fu_ready), 64'hFF);
    cyc();
    fu_done = 8'h00;
    for (int m = 0; m < 10; m++) begin
      chk_lanes($sformatf("full_stall%0d", m), 3'b111, 9'o210);
      chk($sformatf("full_stall%0d.ready", m), 64'(fu_ready), 64'h00);
      cyc();
    end
`ifdef FU_BUF_PERF_EN
    chk("full.stall_cycles", 64'(stall_cycles), 64'd10);
`endif
    cdb_stall = 1'b0;
    #1;
    chk_lanes("full_rel0", 3'b111, 9'o210);
    chk("full_rel0.ready", 64'(fu_ready), 64'h07);
    cyc();
    chk_lanes("full_rel1", 3'b111, 9'o543);
    chk("full_rel1.ready", 64'(fu_ready), 64'h3F);
    cyc();
    chk_lanes("full_rel2", 3'b011, 9'o076);
    cyc();
    chk_lanes("full_rel3", 3'b000, 9'o000);
    // Saturation: FU1 would wrap to 0 below FU6 if ages were not clamped.
    fu_done = 8'h02;
    cdb_stall = 1'b1;
    cyc();
    fu_done = 8'h40;
    #1;
    chk_lanes("sat_fill", 3'b001, 9'o001);
    cyc();
    fu_done = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      chk_lanes($sformatf("sat%0d", k), 3'b011, 9'o061);
      chk($sformatf("sat%0d.ready", k), 64'(fu_ready), 64'hBD);
      cyc();
    end
    cdb_stall = 1'b0;
    #1;
    chk_lanes("sat_rel", 3'b011, 9'o061);
    cyc();
    chk_lanes("sat_empty", 3'b000, 9'o000);
    // Mid-operation reset discards held results.
    fu_done = 8'h0F;
    cdb_stall = 1'b1;
    cyc();
    fu_done = 8'h00;
    #1;
    chk_lanes("mid_held", 3'b111, 9'o210);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cdb_stall = 1'b0;
    #1;
    chk("mid_rst.ready", 64'(fu_ready), 64'hFF);
`ifdef FU_BUF_PERF_EN
    chk("mid_rst.stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    for (int m = 0; m < 3; m++) begin
      chk_lanes($sformatf("mid_rst%0d", m), 3'b000, 9'o000);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
